fifo_uart_tx: RTL and testbench
===============================

// Module: fifo_uart_tx
// PURPOSE
//  Drain stage directly downstream of fifo_single_clk: pops bytes from the FIFO read port, serialises each as an
//  8N1 UART frame on tx (LSB first), then pops the next byte while the FIFO is non-empty. Forms the byte-to-serial
//  transmit path; the FIFO absorbs bursts from the producer.
// PARAMETERS
//  CLKS_PER_BIT  868  clk cycles per UART bit (100 MHz / 115200); legal range 2..65535
//  DATA_W        8    payload width; must match FIFO data width
// PORTS
//  clk           in   1       system clock; all logic on posedge
//  rst_n         in   1       asynchronous, active-low reset
//  enable        in   1       1 = allowed to start new frames; 0 = finish current frame, then hold in IDLE
//  buf_out       in   DATA_W  FIFO read data; valid the cycle after rd_en is sampled high
//  buf_empty     in   1       FIFO empty flag
//  rd_en         out  1       FIFO pop strobe; exactly one cycle per frame
//  tx            out  1       serial line; idles high
//  busy          out  1       high from FETCH through the end of STOP
//  tx_done       out  1       one-cycle pulse on the last cycle of the stop bit
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, tx=1, rd_en=0, busy=0, tx_done=0, bit/baud counters=0.
//  FSM: IDLE -> FETCH -> LOAD -> START -> DATA -> [PARITY] -> STOP -> IDLE | FETCH
//   IDLE:   if enable && !buf_empty -> FETCH. Otherwise stay; tx=1.
//   FETCH:  rd_en=1 for this single cycle -> LOAD.
//   LOAD:   shift_reg <= buf_out; baud counter cleared -> START. tx still 1.
//   START:  tx=0 for CLKS_PER_BIT cycles -> DATA.
//   DATA:   tx=shift_reg[0]; every CLKS_PER_BIT cycles shift right, bit_cnt++; after DATA_W bits -> PARITY|STOP.
//   PARITY: (UART_TX_PARITY_EN only) tx = ^byte (even parity) for CLKS_PER_BIT cycles -> STOP.
//   STOP:   tx=1 for CLKS_PER_BIT cycles; tx_done=1 on the final cycle; then FETCH if enable && !buf_empty,
//           else IDLE.
//  Baud counter: 0..CLKS_PER_BIT-1, wraps; bit boundary when it equals CLKS_PER_BIT-1. Width $clog2(CLKS_PER_BIT).
//  Latency: buf_empty falling in IDLE -> start bit on tx in 3 cycles (FETCH, LOAD, START).
//  Back-to-back frames: stop-to-start gap is exactly 2 cycles of tx=1 (FETCH, LOAD) beyond the stop bit.
//  Boundaries:
//   - rd_en never asserts while buf_empty=1 (checked in IDLE and at STOP exit).
//   - enable dropped mid-frame: the current frame completes unchanged; no further pop.
//   - buf_out is captured only in LOAD; changes at any other time are ignored.
//   - rst_n asserted mid-frame: tx returns to 1 immediately; the partially sent byte is lost (it has already
//     been popped).
//  busy = (state != IDLE). Only tx, rd_en and tx_done are registered outputs; busy is decoded from the state.
// CONFIGURATION
//  `define UART_TX_PARITY_EN: adds the PARITY state; frame is 8E1, 11 bits.
//  Without the macro: the PARITY state and its logic are absent; frame is 8N1, 10 bits; STOP follows the last
//  DATA bit directly.
// STRUCTURE
//  uart_pkg: state encoding localparams (IDLE..STOP, 3 bits), TX_IDLE_LVL=1'b1, default CLKS_PER_BIT.
//  Sub-module uart_baud_tick (CLKS_PER_BIT): counter with a sync clear input and a one-cycle tick output;
//  the top-level FSM uses it for every bit period.
// TESTING (CLKS_PER_BIT=4; FIFO model with 1-cycle read latency)
//  1 Reset: rst_n=0 mid-run -> tx=1, rd_en=0, busy=0, tx_done=0 asynchronously, before the next edge.
//  2 Single byte 8'hA5 pushed, enable=1 -> one rd_en pulse; tx = 0,1,0,1,0,0,1,0,1,1 (4 clk each);
//    tx_done pulses once.
//  3 Bytes 11,12,13 queued -> 3 rd_en pulses, 3 frames in order, exactly 2 idle-high cycles between frames,
//    busy never drops.
//  4 FIFO empty, enable=1 for 100 cycles -> rd_en stays 0, tx stays 1; enable=0 with 5 bytes queued -> no pop.
//  5 Drop enable during DATA of byte 8'h3C -> that frame completes; then IDLE with 4 bytes still in the FIFO.
//  6 UART_TX_PARITY_EN, byte 8'h07 -> parity bit 1 between bit7 and stop; frame lasts 44 cycles.

Source files
------------

// File: rtl/fifo_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_uart_tx_pkg
// Description : Shared constants for the FIFO-fed UART transmitter.
//               State encoding, idle line level and default bit period.
//               Optional feature macro: UART_TX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_uart_tx_pkg;

  localparam int DEF_CLKS_PER_BIT = 868;   // 100 MHz / 115200 baud
  localparam int STATE_W          = 3;

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_FETCH  = 3'd1;
  localparam logic [STATE_W-1:0] ST_LOAD   = 3'd2;
  localparam logic [STATE_W-1:0] ST_START  = 3'd3;
  localparam logic [STATE_W-1:0] ST_DATA   = 3'd4;
  localparam logic [STATE_W-1:0] ST_PARITY = 3'd5;
  localparam logic [STATE_W-1:0] ST_STOP   = 3'd6;

  localparam logic TX_IDLE_LVL = 1'b1;

endpackage
`default_nettype wire

// File: rtl/fifo_uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_uart_tx_if
// Description : FIFO read-port and serial-line bundle for fifo_uart_tx.
//               master = the transmitter, slave = FIFO/line environment.
//               Optional feature macro: UART_TX_PARITY_EN (no effect here).
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_uart_tx_if #(
  parameter int DATA_W = 8
);
  logic              enable;
  logic [DATA_W-1:0] buf_out;
  logic              buf_empty;
  logic              rd_en;
  logic              tx;
  logic              busy;
  logic              tx_done;

  modport master (
    input  enable, buf_out, buf_empty,
    output rd_en, tx, busy, tx_done
  );

  modport slave (
    output enable, buf_out, buf_empty,
    input  rd_en, tx, busy, tx_done
  );
endinterface
`default_nettype wire

// File: rtl/fifo_uart_tx_baud_tick.sv
`default_nettype none
// ============================================================================
// Module      : fifo_uart_tx_baud_tick
// Description : Bit-period counter 0..CLKS_PER_BIT-1 with synchronous clear.
//               tick marks the last cycle of a bit period, pre_tick the cycle
//               before it (lets the parent register end-of-bit strobes).
//               Optional feature macro: UART_TX_PARITY_EN (no effect here).
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_uart_tx_baud_tick #(
  parameter int CLKS_PER_BIT = 868
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic clr,
  output logic      tick,
  output logic      pre_tick
);

  localparam int              CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] PRE  = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] r_cnt;

  // Free-running wrap counter; clear forces it back to the start of a bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign tick     = !clr && (r_cnt == LAST);
  assign pre_tick = !clr && (r_cnt == PRE);

endmodule
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : fifo_uart_tx
// Description : Pops bytes from a single-clock FIFO (1-cycle read latency) and
//               sends each as a UART frame, LSB first, on tx.
//               Default frame 8N1; with `define UART_TX_PARITY_EN an even
//               parity bit is inserted (8E1).
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_W       = 8
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  fifo_uart_tx_if.master bus
);

  localparam int               BIT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next_state;
  logic [DATA_W-1:0]  r_shift;
  logic [DATA_W-1:0]  w_shift_nxt;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic               w_tx_nxt;
  logic               w_tick;
  logic               w_pre_tick;
  logic               w_baud_clr;
  logic               w_can_start;
`ifdef UART_TX_PARITY_EN
  logic               r_parity;
`endif

  assign w_can_start = bus.enable && !bus.buf_empty;
  // Hold the bit timer at zero until the start bit begins.
  assign w_baud_clr  = (r_state == ST_IDLE) || (r_state == ST_FETCH) || (r_state == ST_LOAD);

  fifo_uart_tx_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (w_baud_clr),
    .tick     (w_tick),
    .pre_tick (w_pre_tick)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic; enable only matters when deciding to begin a new frame.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (w_can_start) w_next_state = ST_FETCH;
      ST_FETCH:  w_next_state = ST_LOAD;
      ST_LOAD:   w_next_state = ST_START;
      ST_START:  if (w_tick) w_next_state = ST_DATA;
`ifdef UART_TX_PARITY_EN
      ST_DATA:   if (w_tick && (r_bit_cnt == LAST_BIT)) w_next_state = ST_PARITY;
      ST_PARITY: if (w_tick) w_next_state = ST_STOP;
`else
      ST_DATA:   if (w_tick && (r_bit_cnt == LAST_BIT)) w_next_state = ST_STOP;
`endif
      ST_STOP:   if (w_tick) w_next_state = w_can_start ? ST_FETCH : ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so tx lines up with the state change.
  always_comb begin
    w_shift_nxt = r_shift;
    if (r_state == ST_LOAD) begin
      w_shift_nxt = bus.buf_out;
    end else if ((r_state == ST_DATA) && w_tick) begin
      w_shift_nxt = r_shift >> 1;
    end
    w_tx_nxt = TX_IDLE_LVL;
    case (w_next_state)
      ST_START:  w_tx_nxt = 1'b0;
      ST_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: w_tx_nxt = r_parity;
`endif
      default:   w_tx_nxt = TX_IDLE_LVL;
    endcase
  end

  // Registered outputs; tx_done is pre-armed one cycle before the stop bit ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.tx      <= TX_IDLE_LVL;
      bus.rd_en   <= 1'b0;
      bus.tx_done <= 1'b0;
    end else begin
      bus.tx      <= w_tx_nxt;
      bus.rd_en   <= (w_next_state == ST_FETCH);
      bus.tx_done <= (r_state == ST_STOP) && w_pre_tick;
    end
  end

  // Payload shifter and bit counter; data is captured only in LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_shift <= w_shift_nxt;
      if (r_state == ST_LOAD) begin
        r_bit_cnt <= '0;
      end else if ((r_state == ST_DATA) && w_tick) begin
        r_bit_cnt <= (r_bit_cnt == LAST_BIT) ? '0 : r_bit_cnt + BIT_W'(1);
      end
    end
  end

`ifdef UART_TX_PARITY_EN
  // Even parity of the byte, computed while it is loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   r_parity <= 1'b0;
    else if (r_state == ST_LOAD)  r_parity <= ^bus.buf_out;
  end
`endif

  assign bus.busy = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_uart_tx
// Description : Self-checking bench for fifo_uart_tx with CLKS_PER_BIT=4 and a
//               1-cycle-latency FIFO model. Directed frame table plus
//               hand-written burst, enable, and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int NVEC = 8;

  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;   // bit i = i-th bit on the line (start first)
  } vec_t;

  logic clk;
  logic rst_n;

  fifo_uart_tx_if #(.DATA_W(8)) bus ();

  fifo_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .DATA_W       (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: 16 entries, data valid the cycle after rd_en is sampled.
  logic [7:0] mem [0:15];
  int wp = 0;
  int rp = 0;
  int pops = 0;
  int bad_pops = 0;
  int dones = 0;

  assign bus.buf_empty = (wp == rp);

  always @(posedge clk) begin
    if (bus.rd_en) begin
      pops <= pops + 1;
      if (wp == rp) begin
        bad_pops <= bad_pops + 1;
      end else begin
        bus.buf_out <= mem[rp % 16];
        rp <= rp + 1;
      end
    end
    if (bus.tx_done) dones <= dones + 1;
  end

  int checks = 0;
  int errors = 0;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    mem[wp % 16] = d;
    wp = wp + 1;
  endtask

  // Captures one frame (NB bits x CPB cycles); optionally drops enable at a bit.
  task automatic run_frame(input logic [10:0] exp, input string name,
                           input int drop_at, output int busy_lost);
    logic [10:0] cap;
    int bad;
    logic done_last;
    cap = '0;
    bad = 0;
    busy_lost = 0;
    done_last = 1'b0;
    for (int b = 0; b < NB; b++) begin
      for (int k = 0; k < CPB; k++) begin
        step();
        if (bus.tx !== exp[b]) bad++;
        if (k == 1) cap[b] = bus.tx;
        if (bus.busy !== 1'b1) busy_lost++;
        if ((b == NB - 1) && (k == CPB - 1)) done_last = bus.tx_done;
        if ((b == drop_at) && (k == 0)) bus.enable = 1'b0;
      end
    end
    chk({name, "_bits"}, int'(cap), int'(exp));
    chk({name, "_cyc_err"}, bad, 0);
    chk({name, "_done_last"}, int'(done_last), 1);
  endtask

  task automatic fetch_load(input string name);
    step();
    chk({name, "_fetch"}, int'({bus.rd_en, bus.tx, bus.busy}), 3'b111);
    step();
    chk({name, "_load"}, int'({bus.rd_en, bus.tx, bus.busy}), 3'b011);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int p0, d0, bl, bl_sum, bad, waited;
`ifdef UART_TX_PARITY_EN
    vecs[0] = '{8'hA5, 11'h54A};
    vecs[1] = '{8'h11, 11'h422};
    vecs[2] = '{8'h12, 11'h424};
    vecs[3] = '{8'h13, 11'h626};
    vecs[4] = '{8'h3C, 11'h478};
    vecs[5] = '{8'h00, 11'h400};
    vecs[6] = '{8'hFF, 11'h5FE};
    vecs[7] = '{8'h07, 11'h60E};
`else
    vecs[0] = '{8'hA5, 11'h34A};
    vecs[1] = '{8'h11, 11'h222};
    vecs[2] = '{8'h12, 11'h224};
    vecs[3] = '{8'h13, 11'h226};
    vecs[4] = '{8'h3C, 11'h278};
    vecs[5] = '{8'h00, 11'h200};
    vecs[6] = '{8'hFF, 11'h3FE};
    vecs[7] = '{8'h07, 11'h20E};
`endif

    // Reset state.
    rst_n = 1'b0;
    bus.enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", int'({bus.tx, bus.rd_en, bus.busy, bus.tx_done}), 4'b1000);
    @(negedge clk);
    rst_n = 1'b1;
    bus.enable = 1'b1;
    step();
    step();

    // Table: one byte at a time from an idle, empty FIFO.
    for (int i = 0; i < NVEC; i++) begin
      string nm;
      nm = $sformatf("vec%0d_%02h", i, vecs[i].data);
      p0 = pops;
      d0 = dones;
      @(negedge clk);
      push(vecs[i].data);
      fetch_load(nm);
      run_frame(vecs[i].frame, nm, -1, bl);
      chk({nm, "_busy_lost"}, bl, 0);
      step();
      chk({nm, "_idle_after"}, int'({bus.busy, bus.tx, bus.rd_en}), 3'b010);
      chk({nm, "_pops"}, pops - p0, 1);
      chk({nm, "_dones"}, dones - d0, 1);
    end

    // Burst of three: back-to-back frames, two high cycles between them.
    p0 = pops;
    d0 = dones;
    bl_sum = 0;
    @(negedge clk);
    push(8'h11);
    push(8'h12);
    push(8'h13);
    for (int j = 0; j < 3; j++) begin
      fetch_load($sformatf("burst%0d", j));
      run_frame(vecs[1 + j].frame, $sformatf("burst%0d", j), -1, bl);
      bl_sum += bl;
    end
    chk("burst_busy_lost", bl_sum, 0);
    step();
    chk("burst_idle_after", int'({bus.busy, bus.tx}), 2'b01);
    chk("burst_pops", pops - p0, 3);
    chk("burst_dones", dones - d0, 3);

    // Empty FIFO with enable high: nothing happens.
    p0 = pops;
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      step();
      if (bus.tx !== 1'b1 || bus.rd_en !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    chk("empty_quiet", bad, 0);
    chk("empty_pops", pops - p0, 0);

    // Bytes queued with enable low: no pop.
    @(negedge clk);
    bus.enable = 1'b0;
    push(8'h3C);
    push(8'h01);
    push(8'h02);
    push(8'h03);
    push(8'h04);
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      step();
      if (bus.tx !== 1'b1 || bus.rd_en !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    chk("disabled_quiet", bad, 0);
    chk("disabled_pops", pops - p0, 0);

    // Enable on, then dropped during the data bits of 0x3C.
    @(negedge clk);
    bus.enable = 1'b1;
    fetch_load("drop");
    run_frame(vecs[4].frame, "drop", 3, bl);
    chk("drop_busy_lost", bl, 0);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (bus.busy !== 1'b0 || bus.tx !== 1'b1) bad++;
    end
    chk("drop_idle", bad, 0);
    chk("drop_pops", pops - p0, 1);
    chk("drop_level", wp - rp, 4);

    // Drain the remaining four bytes.
    @(negedge clk);
    bus.enable = 1'b1;
    step();
    waited = 0;
    while (!((wp == rp) && (bus.busy == 1'b0)) && waited < 400) begin
      step();
      waited++;
    end
    chk("drain_timeout", int'(waited < 400), 1);
    chk("drain_pops", pops - p0, 5);

    // Reset in the middle of a data bit of 0x00.
    p0 = pops;
    @(negedge clk);
    push(8'h00);
    fetch_load("rst");
    repeat (CPB + 2 * CPB) step();
    chk("rst_pre_tx", int'({bus.tx, bus.busy}), 2'b01);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", int'({bus.tx, bus.rd_en, bus.busy, bus.tx_done}), 4'b1000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (bus.busy !== 1'b0 || bus.tx !== 1'b1 || bus.rd_en !== 1'b0) bad++;
    end
    chk("rst_after_idle", bad, 0);
    chk("rst_pops", pops - p0, 1);
    chk("no_pop_when_empty", bad_pops, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
